cam_i2c_responder: RTL

- I2C target that emulates the IR camera at 7-bit address 0x58 for simulation and board-level loopback of the camera driver and i2c_master.
- Accepts register writes: config pairs such as 0x30/0x01, 0x30/0x08 and 0x33/0x33, plus pointer-only writes of 0x36.
- Serves 16-byte position frames from 0x36 in the extended format the driver decodes.
- Sits on the same SDA/SCL pins as i2c_master, with blob coordinates supplied by a testbench or a synthetic pattern source.

---
 rtl/cam_pkg.sv | 30 +++
 rtl/i2c_line_sync.sv | 63 ++++++
 rtl/cam_i2c_responder.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_pkg.sv
// -----------------------------------------------------------------------------
// cam_pkg
// Shared constants and the responder state type for the IR camera I2C target
// model (cam_i2c_responder).
//   CAM_I2C_ADDR : default 7-bit bus address of the emulated camera
//   REG_CTRL     : control register (written 0x01 / 0x08 by the driver)
//   REG_MODE     : mode register (written 0x33 by the driver)
//   REG_FRAME    : pointer at which the 16-byte position frame begins
//   FRAME_LEN    : bytes in one position frame
// -----------------------------------------------------------------------------
package cam_pkg;

  localparam logic [6:0] CAM_I2C_ADDR = 7'h58;
  localparam logic [7:0] REG_CTRL     = 8'h30;
  localparam logic [7:0] REG_MODE     = 8'h33;
  localparam logic [7:0] REG_FRAME    = 8'h36;
  localparam int         FRAME_LEN    = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_IGNORE
  } cam_state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// -----------------------------------------------------------------------------
// i2c_line_sync
// Brings the asynchronous SCL/SDA pins into the clk domain and produces
// single-cycle bus event pulses.
//   i_clk, i_reset   : system clock, async active-high reset
//   i_scl, i_sda     : raw bus lines
//   o_scl_rise/fall  : SCL edge pulses
//   o_start_det      : SDA fell while SCL high
//   o_stop_det       : SDA rose while SCL high
//   o_sda            : synchronized SDA, aligned with the pulses above
// Every pulse appears 3 clk after the pin change (2 sync flops + 1 register).
// -----------------------------------------------------------------------------
module i2c_line_sync (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start_det,
  output logic o_stop_det,
  output logic o_sda
);

  logic r_scl_s1, r_scl_s2, r_scl_d;
  logic r_sda_s1, r_sda_s2, r_sda_d;
  logic r_scl_rise, r_scl_fall, r_start, r_stop;

  // Flops reset to 1 so a released (idle) bus produces no spurious events.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_scl_s1   <= 1'b1;
      r_scl_s2   <= 1'b1;
      r_scl_d    <= 1'b1;
      r_sda_s1   <= 1'b1;
      r_sda_s2   <= 1'b1;
      r_sda_d    <= 1'b1;
      r_scl_rise <= 1'b0;
      r_scl_fall <= 1'b0;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
    end else begin
      r_scl_s1   <= i_scl;
      r_scl_s2   <= r_scl_s1;
      r_scl_d    <= r_scl_s2;
      r_sda_s1   <= i_sda;
      r_sda_s2   <= r_sda_s1;
      r_sda_d    <= r_sda_s2;
      r_scl_rise <= r_scl_s2 & ~r_scl_d;
      r_scl_fall <= ~r_scl_s2 & r_scl_d;
      r_start    <= r_scl_s2 & r_scl_d & ~r_sda_s2 & r_sda_d;
      r_stop     <= r_scl_s2 & r_scl_d & r_sda_s2 & ~r_sda_d;
    end
  end

  assign o_scl_rise  = r_scl_rise;
  assign o_scl_fall  = r_scl_fall;
  assign o_start_det = r_start;
  assign o_stop_det  = r_stop;
  // r_sda_d is the value the pulses were computed from, so it lines up with them.
  assign o_sda       = r_sda_d;

endmodule

// File: rtl/cam_i2c_responder.sv
// -----------------------------------------------------------------------------
// cam_i2c_responder
// I2C target emulating the IR camera: accepts config register writes and
// pointer writes, serves 16-byte position frames starting at FRAME_BASE.
// Ports:
//   clk, reset          : system clock (>= 8x SCL), async active-high reset
//   i2c_scl, i2c_sda_in : bus lines
//   i2c_sda             : SDA drive value (constant 0)
//   i2c_sda_dir         : 1 = pull SDA low, 0 = release
//   blob_x/y/size/valid : blob 0 data, latched at each read address ACK
//   cfg_30, cfg_33      : last values written to registers 0x30 / 0x33
//   busy                : high between START and STOP
// Optional (macro CAM_RESP_DEBUG_EN):
//   debug[7:0]      : last byte received or transmitted
//   xact_count[7:0] : count of STOPs ending an addressed transaction
// -----------------------------------------------------------------------------
module cam_i2c_responder
  import cam_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR   = CAM_I2C_ADDR,
  parameter logic [7:0] FRAME_BASE = REG_FRAME,
  parameter int         FRAME_LEN  = cam_pkg::FRAME_LEN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2c_scl,
  input  logic       i2c_sda_in,
  output logic       i2c_sda,
  output logic       i2c_sda_dir,
  input  logic [9:0] blob_x,
  input  logic [9:0] blob_y,
  input  logic [3:0] blob_size,
  input  logic       blob_valid,
  output logic [7:0] cfg_30,
  output logic [7:0] cfg_33,
  output logic       busy
`ifdef CAM_RESP_DEBUG_EN
  ,
  output logic [7:0] debug,
  output logic [7:0] xact_count
`endif
);

  localparam logic [7:0] LP_LEN = 8'(FRAME_LEN);

  logic w_scl_rise, w_scl_fall, w_start, w_stop, w_sda;

  i2c_line_sync u_sync (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_scl       (i2c_scl),
    .i_sda       (i2c_sda_in),
    .o_scl_rise  (w_scl_rise),
    .o_scl_fall  (w_scl_fall),
    .o_start_det (w_start),
    .o_stop_det  (w_stop),
    .o_sda       (w_sda)
  );

  cam_state_e r_state;
  logic [7:0] r_shift, r_tx, r_ptr, r_frame_cnt, r_snap_cnt;
  logic [7:0] r_cfg_30, r_cfg_33;
  logic [2:0] r_bit_cnt;
  logic       r_byte_done, r_rw, r_first, r_sda_dir, r_busy;
  logic [9:0] r_snap_x, r_snap_y;
  logic [3:0] r_snap_size;
  logic       r_snap_valid;
`ifdef CAM_RESP_DEBUG_EN
  logic [7:0] r_debug, r_xact_cnt;
  logic       r_addressed;
`endif

  // Byte served at the current pointer, taken from the snapshot so one read
  // never mixes data from two blob updates.
  logic [7:0] w_off, w_rd_byte;
  always_comb begin
    w_off     = r_ptr - FRAME_BASE;
    w_rd_byte = 8'h00;
    if (w_off < LP_LEN) begin
      case (w_off)
        8'd0:    w_rd_byte = r_snap_cnt;
        8'd1:    w_rd_byte = r_snap_valid ? r_snap_x[7:0] : 8'hFF;
        8'd2:    w_rd_byte = r_snap_valid ? r_snap_y[7:0] : 8'hFF;
        8'd3:    w_rd_byte = r_snap_valid ? {r_snap_y[9:8], r_snap_x[9:8], r_snap_size} : 8'hFF;
        default: w_rd_byte = 8'hFF;
      endcase
    end else if (r_ptr == REG_CTRL) begin
      w_rd_byte = r_cfg_30;
    end else if (r_ptr == REG_MODE) begin
      w_rd_byte = r_cfg_33;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_shift      <= 8'h00;
      r_tx         <= 8'h00;
      r_ptr        <= 8'h00;
      r_frame_cnt  <= 8'h00;
      r_snap_cnt   <= 8'h00;
      r_cfg_30     <= 8'h00;
      r_cfg_33     <= 8'h00;
      r_bit_cnt    <= 3'd0;
      r_byte_done  <= 1'b0;
      r_rw         <= 1'b0;
      r_first      <= 1'b0;
      r_sda_dir    <= 1'b0;
      r_busy       <= 1'b0;
      r_snap_x     <= 10'd0;
      r_snap_y     <= 10'd0;
      r_snap_size  <= 4'd0;
      r_snap_valid <= 1'b0;
`ifdef CAM_RESP_DEBUG_EN
      r_debug      <= 8'h00;
      r_xact_cnt   <= 8'h00;
      r_addressed  <= 1'b0;
`endif
    end else if (w_stop) begin
      r_state   <= ST_IDLE;
      r_busy    <= 1'b0;
      r_sda_dir <= 1'b0;
`ifdef CAM_RESP_DEBUG_EN
      if (r_addressed) r_xact_cnt <= r_xact_cnt + 8'd1;
      r_addressed <= 1'b0;
`endif
    end else if (w_start) begin
      r_state     <= ST_ADDR;
      r_busy      <= 1'b1;
      r_sda_dir   <= 1'b0;
      r_bit_cnt   <= 3'd0;
      r_byte_done <= 1'b0;
    end else begin
      case (r_state)
        ST_ADDR, ST_WR_BYTE: begin
          if (w_scl_rise) begin
            r_shift     <= {r_shift[6:0], w_sda};
            r_bit_cnt   <= r_bit_cnt + 3'd1;
            r_byte_done <= (r_bit_cnt == 3'd7);
          end else if (w_scl_fall && r_byte_done) begin
            // Falling edge after the 8th bit: decide, then drive the ACK.
            r_byte_done <= 1'b0;
            r_bit_cnt   <= 3'd0;
`ifdef CAM_RESP_DEBUG_EN
            r_debug     <= r_shift;
`endif
            if (r_state == ST_ADDR) begin
              if (r_shift[7:1] == I2C_ADDR) begin
                r_state   <= ST_ADDR_ACK;
                r_sda_dir <= 1'b1;
                r_rw      <= r_shift[0];
`ifdef CAM_RESP_DEBUG_EN
                r_addressed <= 1'b1;
`endif
                if (r_shift[0]) begin
                  r_snap_x     <= blob_x;
                  r_snap_y     <= blob_y;
                  r_snap_size  <= blob_size;
                  r_snap_valid <= blob_valid;
                  r_snap_cnt   <= r_frame_cnt;
                  r_frame_cnt  <= r_frame_cnt + 8'd1;
                end
              end else begin
                r_state <= ST_IGNORE;
              end
            end else begin
              r_state   <= ST_WR_ACK;
              r_sda_dir <= 1'b1;
              if (r_first) begin
                r_ptr   <= r_shift;
                r_first <= 1'b0;
              end else begin
                if (r_ptr == REG_CTRL) r_cfg_30 <= r_shift;
                if (r_ptr == REG_MODE) r_cfg_33 <= r_shift;
                r_ptr <= r_ptr + 8'd1;
              end
            end
          end
        end
        ST_ADDR_ACK: begin
          if (w_scl_fall) begin
            r_bit_cnt <= 3'd0;
            if (r_rw) begin
              r_state   <= ST_RD_BYTE;
              r_tx      <= w_rd_byte;
              r_sda_dir <= ~w_rd_byte[7];
`ifdef CAM_RESP_DEBUG_EN
              r_debug   <= w_rd_byte;
`endif
            end else begin
              r_state   <= ST_WR_BYTE;
              r_sda_dir <= 1'b0;
              r_first   <= 1'b1;
            end
          end
        end
        ST_WR_ACK: begin
          if (w_scl_fall) begin
            r_state   <= ST_WR_BYTE;
            r_sda_dir <= 1'b0;
          end
        end
        ST_RD_BYTE: begin
          // Bit 7 went out on entry; each fall presents the next bit, and
          // the fall after bit 0 releases SDA for the master's ACK/NACK.
          if (w_scl_fall) begin
            if (r_bit_cnt == 3'd7) begin
              r_state   <= ST_RD_ACK;
              r_sda_dir <= 1'b0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_tx      <= {r_tx[6:0], 1'b0};
              r_sda_dir <= ~r_tx[6];
            end
          end
        end
        ST_RD_ACK: begin
          if (w_scl_rise) begin
            if (!w_sda) r_ptr   <= r_ptr + 8'd1;
            else        r_state <= ST_IGNORE;
          end else if (w_scl_fall) begin
            // Pointer already advanced on the ACK rise, so w_rd_byte is the next byte.
            r_state   <= ST_RD_BYTE;
            r_bit_cnt <= 3'd0;
            r_tx      <= w_rd_byte;
            r_sda_dir <= ~w_rd_byte[7];
`ifdef CAM_RESP_DEBUG_EN
            r_debug   <= w_rd_byte;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign i2c_sda     = 1'b0;
  assign i2c_sda_dir = r_sda_dir;
  assign cfg_30      = r_cfg_30;
  assign cfg_33      = r_cfg_33;
  assign busy        = r_busy;
`ifdef CAM_RESP_DEBUG_EN
  assign debug       = r_debug;
  assign xact_count  = r_xact_cnt;
`endif

endmodule
